// File: rtl/iob_ptfloat_pack_pkg.sv
// Shared definitions for the pt-float packing stage: default geometry and FSM state encoding.
package iob_ptfloat_pack_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_EW_W   = 4;
    localparam int EXP_MAX_W  = (2 ** DEF_EW_W) - 1;
    localparam int MAN_MAX_W  = DEF_DATA_W - DEF_EW_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/iob_ptfloat_round.sv
// Combinational round-to-nearest-even of a left-aligned mantissa down to its top mw_i bits.
// man_o is right-aligned; only its low mw_i bits are meaningful.
module iob_ptfloat_round #(
    parameter int MAN_W = 28,
    parameter int MW_W  = 5
) (
    input  logic [MAN_W-1:0] man_i,
    input  logic [MW_W-1:0]  mw_i,
    output logic [MAN_W-1:0] man_o,
    output logic             ovf_o,
    output logic             renorm_o
);

    localparam logic [MW_W-1:0]  MAN_W_C = MW_W'(MAN_W);
    localparam logic [MAN_W-1:0] ONE     = MAN_W'(1);

    logic [MW_W-1:0]         drop;
    logic signed [MAN_W-1:0] kept;
    logic [MAN_W-1:0]        low_mask;
    logic [MAN_W-1:0]        guard_mask;
    logic [MAN_W-1:0]        sum;
    logic [1:0]              top2;
    logic                    guard;
    logic                    sticky;
    logic                    rnd;

    always_comb begin
        drop       = MAN_W_C - mw_i;
        kept       = $signed(man_i) >>> drop;
        low_mask   = (ONE << drop) - ONE;
        guard_mask = (drop == '0) ? '0 : (ONE << (drop - 1'b1));
        guard      = |(man_i & guard_mask);
        sticky     = |(man_i & low_mask & ~guard_mask);
        rnd        = guard & (sticky | kept[0]);
        sum        = $unsigned(kept) + MAN_W'(rnd);
        // the two most significant bits of the mw_i-bit result
        top2       = 2'(sum >> (mw_i - 2'd2));
        ovf_o      = ~man_i[MAN_W-1] & top2[1];
        renorm_o   = man_i[MAN_W-1] & top2[1] & top2[0];
        man_o      = sum;
    end

endmodule

// File: rtl/iob_ptfloat_pack.sv
// Pt-float packing stage: chooses the narrowest exponent field and rounds the mantissa (RNE) into the rest.
// Define IOB_PTFLOAT_PACK_LZC_EN to size the exponent field in one cycle instead of iteratively.
module iob_ptfloat_pack
    import iob_ptfloat_pack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int EW_W   = DEF_EW_W
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     cke_i,
    input  logic                     start_i,
    output logic                     done_o,
    output logic                     overflow_o,
    input  logic [(2**EW_W)-2:0]     exp_i,
    input  logic [DATA_W-EW_W-1:0]   man_i,
    output logic [DATA_W-1:0]        data_o
);

    localparam int EXP_W = (2 ** EW_W) - 1;
    localparam int MAN_W = DATA_W - EW_W;
    localparam int MW_W  = $clog2(MAN_W + 1);

    localparam logic [EXP_W-1:0]  EXP_POS_MAX = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0]  EXP_NEG_MIN = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic [MAN_W-1:0]  MAN_ONE_POS = {2'b01, {(MAN_W-2){1'b0}}};
    localparam logic [MAN_W-1:0]  MAN_ONE_NEG = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] SAT_POS = {{EW_W{1'b1}}, 1'b0, {(EXP_W-1){1'b1}},
                                             1'b0, {(MAN_W-EXP_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_NEG = {{EW_W{1'b1}}, 1'b0, {(EXP_W-1){1'b1}},
                                             1'b1, {(MAN_W-EXP_W-1){1'b0}}};

    // true when e is representable as a w-bit two's complement value (w=0 holds only zero)
    function automatic logic exp_fits(input logic [EXP_W-1:0] e, input logic [EW_W-1:0] w);
        logic signed [EXP_W-1:0] t;
        if (w == '0) return (e == '0);
        t = e << (EXP_W - int'(w));
        t = t >>> (EXP_W - int'(w));
        return (t == $signed(e));
    endfunction

`ifdef IOB_PTFLOAT_PACK_LZC_EN
    function automatic logic [EW_W-1:0] exp_width(input logic [EXP_W-1:0] e);
        logic [EW_W-1:0] w;
        w = EW_W'(EXP_W);
        for (int i = EXP_W - 1; i >= 0; i--)
            if (exp_fits(e, EW_W'(i))) w = EW_W'(i);
        return w;
    endfunction
`endif

    state_t            state, state_nxt;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [MAN_W-1:0]  man_q, man_d;
    logic [EW_W-1:0]   ew_q, ew_d;
    logic              sat_q, sat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic [MW_W-1:0]   mw;
    logic [MAN_W-1:0]  man_r;
    logic              rnd_ovf;
    logic              rnd_renorm;
    logic              saturate;
    logic              renorm_up;
    logic              renorm_dn;
    logic [DATA_W-1:0] exp_mask;
    logic [DATA_W-1:0] man_mask;
    logic [DATA_W-1:0] packed_word;

    assign mw = MW_W'(MAN_W) - MW_W'(ew_q);

    iob_ptfloat_round #(
        .MAN_W (MAN_W),
        .MW_W  (MW_W)
    ) u_round (
        .man_i    (man_q),
        .mw_i     (mw),
        .man_o    (man_r),
        .ovf_o    (rnd_ovf),
        .renorm_o (rnd_renorm)
    );

    // a renorm that would push the exponent out of range saturates (up) or is skipped (down)
    assign saturate  = rnd_ovf & (exp_q == EXP_POS_MAX);
    assign renorm_up = rnd_ovf & (exp_q != EXP_POS_MAX);
    assign renorm_dn = rnd_renorm & (exp_q != EXP_NEG_MIN);

    always_comb begin
        exp_mask    = (DATA_W'(1) << ew_q) - DATA_W'(1);
        man_mask    = (DATA_W'(1) << mw) - DATA_W'(1);
        packed_word = (DATA_W'(ew_q) << MAN_W)
                    | ((DATA_W'(exp_q) & exp_mask) << mw)
                    | (DATA_W'(man_r) & man_mask);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)     state <= IDLE;
        else if (cke_i) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_i) state_nxt = SEARCH;
`ifdef IOB_PTFLOAT_PACK_LZC_EN
            SEARCH: state_nxt = ROUND;
`else
            SEARCH: if (exp_fits(exp_q, ew_q)) state_nxt = ROUND;
`endif
            ROUND:  state_nxt = (renorm_up || renorm_dn) ? SEARCH : DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        exp_d  = exp_q;
        man_d  = man_q;
        ew_d   = ew_q;
        sat_d  = sat_q;
        data_d = data_q;
        done_d = 1'b0;
        ovf_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    // a zero mantissa is packed with a zero-width exponent
                    exp_d = (man_i == '0) ? '0 : exp_i;
                    man_d = man_i;
                    ew_d  = '0;
                    sat_d = 1'b0;
                end
            end
`ifdef IOB_PTFLOAT_PACK_LZC_EN
            SEARCH: ew_d = exp_width(exp_q);
`else
            SEARCH: if (!exp_fits(exp_q, ew_q)) ew_d = ew_q + 1'b1;
`endif
            ROUND: begin
                if (saturate) begin
                    data_d = man_q[MAN_W-1] ? SAT_NEG : SAT_POS;
                    sat_d  = 1'b1;
                end else if (renorm_up) begin
                    exp_d = exp_q + 1'b1;
                    man_d = MAN_ONE_POS;
                    ew_d  = '0;
                end else if (renorm_dn) begin
                    exp_d = exp_q - 1'b1;
                    man_d = MAN_ONE_NEG;
                    ew_d  = '0;
                end else begin
                    data_d = packed_word;
                end
            end
            DONE: begin
                done_d = 1'b1;
                ovf_d  = sat_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            exp_q  <= '0;
            man_q  <= '0;
            ew_q   <= '0;
            sat_q  <= 1'b0;
            data_q <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (cke_i) begin
            exp_q  <= exp_d;
            man_q  <= man_d;
            ew_q   <= ew_d;
            sat_q  <= sat_d;
            data_q <= data_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign done_o     = done_q;
    assign overflow_o = ovf_q;
    assign data_o     = data_q;

endmodule

// File: tb/tb_iob_ptfloat_pack.sv
// Directed bench for iob_ptfloat_pack: vector table plus reset, clock-enable and start-in-DONE sequences.
module tb_iob_ptfloat_pack;

    typedef struct {
        logic [14:0] e;
        logic [27:0] m;
        logic [31:0] d;
        logic        ovf;
        int          lat_it;
        int          lat_lzc;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst;
    logic        cke;
    logic        start;
    logic        done;
    logic        ovf;
    logic [14:0] exp_in;
    logic [27:0] man_in;
    logic [31:0] data;

    int checks = 0;
    int errors = 0;
    vec_t vecs[13];

    always #5 clk = ~clk;

    iob_ptfloat_pack dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .cke_i      (cke),
        .start_i    (start),
        .done_o     (done),
        .overflow_o (ovf),
        .exp_i      (exp_in),
        .man_i      (man_in),
        .data_o     (data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic launch(input logic [14:0] e, input logic [27:0] m);
        @(negedge clk);
        exp_in = e;
        man_in = m;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        int lat;
        int lat_exp;
        int n;

        //          exp       man           data          ovf  it  lzc
        vecs[0]  = '{15'h0000, 28'h4000000, 32'h04000000, 1'b0, 3,  3};
        vecs[1]  = '{15'h0001, 28'h4000000, 32'h25000000, 1'b0, 5,  3};
        vecs[2]  = '{15'h7FFF, 28'h4000000, 32'h1A000000, 1'b0, 4,  3};
        vecs[3]  = '{15'h0001, 28'h4000003, 32'h25000001, 1'b0, 5,  3};
        vecs[4]  = '{15'h0001, 28'h7FFFFFE, 32'h34800000, 1'b0, 10, 5};
        vecs[5]  = '{15'h1234, 28'h0000000, 32'h00000000, 1'b0, 3,  3};
        vecs[6]  = '{15'h0001, 28'h4000002, 32'h25000000, 1'b0, 5,  3};
        vecs[7]  = '{15'h0001, 28'h4000006, 32'h25000002, 1'b0, 5,  3};
        vecs[8]  = '{15'h0001, 28'hBFFFFFE, 32'h08000000, 1'b0, 7,  5};
        vecs[9]  = '{15'h0002, 28'h8000000, 32'h35000000, 1'b0, 6,  3};
        vecs[10] = '{15'h7F9C, 28'h4000000, 32'h89C40000, 1'b0, 11, 3};
        vecs[11] = '{15'h4000, 28'h4000000, 32'hF8000800, 1'b0, 18, 3};
        vecs[12] = '{15'h3FFF, 28'h7FFFFFF, 32'hF7FFEFFF, 1'b1, 18, 3};

        arst   = 1'b1;
        cke    = 1'b1;
        start  = 1'b0;
        exp_in = '0;
        man_in = '0;
        #12;
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_data", data, 32'h0);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 13; i++) begin
`ifdef IOB_PTFLOAT_PACK_LZC_EN
            lat_exp = vecs[i].lat_lzc;
`else
            lat_exp = vecs[i].lat_it;
`endif
            launch(vecs[i].e, vecs[i].m);
            wait_done(40, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(lat_exp));
            check($sformatf("vec%0d_data", i), data, vecs[i].d);
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_ovf_clear", i), 32'(ovf), 32'd0);
        end

        // four gated edges stretch the operation by exactly four cycles
        launch(15'h0000, 28'h4000000);
        cke = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) cke = 1'b1;
            if (done) begin
                lat = c;
                break;
            end
        end
        cke = 1'b1;
        check("cke_latency", 32'(lat), 32'd7);
        check("cke_data", data, 32'h04000000);

        // start raised during the DONE cycle must be ignored
        launch(15'h0000, 28'h4000000);
        repeat (2) @(posedge clk);
        #1;
        start  = 1'b1;
        exp_in = 15'h0001;
        man_in = 28'h4000006;
        @(posedge clk);
        #1 start = 1'b0;
        check("done_cycle_pulse", 32'(done), 32'd1);
        check("done_cycle_data", data, 32'h04000000);
        count_pulses(20, n);
        check("start_in_done_ignored", 32'(n), 32'd0);

        // reset in SEARCH aborts the operation with no done pulse
        launch(15'h3FFF, 28'h4000000);
        arst = 1'b1;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_data", data, 32'h0);
        check("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        count_pulses(25, n);
        check("abort_no_pulse", 32'(n), 32'd0);
        check("abort_data_held", data, 32'h0);

        launch(15'h7FFF, 28'h4000000);
        wait_done(40, lat);
`ifdef IOB_PTFLOAT_PACK_LZC_EN
        check("recover_latency", 32'(lat), 32'd3);
`else
        check("recover_latency", 32'(lat), 32'd4);
`endif
        check("recover_data", data, 32'h1A000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
